// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table checker for a two-input, two-output function stage:
// drives {x,y} = 00..11, lets each vector settle, and scores s1/s2 against latched tables.
module tt_sweep_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] exp_s1,
    input  logic [3:0] exp_s2,
    input  logic       s1_in,
    input  logic       s2_in,
    output logic       x_out,
    output logic       y_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_mask
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] idx;
    logic [3:0] settle_cnt;
    logic [3:0] exp_s1_q;
    logic [3:0] exp_s2_q;

    logic       mis_s1;
    logic       mis_s2;
    logic [3:0] err_next;
    logic [7:0] mask_next;

    // Case inequality so an unknown response is scored as a mismatch in simulation.
    always_comb begin
        mis_s1    = (s1_in !== exp_s1_q[idx]);
        mis_s2    = (s2_in !== exp_s2_q[idx]);
        err_next  = err_count + 4'(mis_s1) + 4'(mis_s2);
        mask_next = fail_mask;
        if (mis_s1) mask_next[{idx, 1'b0}] = 1'b1;
        if (mis_s2) mask_next[{idx, 1'b1}] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            exp_s1_q   <= '0;
            exp_s2_q   <= '0;
            x_out      <= 1'b0;
            y_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    x_out <= 1'b0;
                    y_out <= 1'b0;
                    if (start) begin
                        exp_s1_q   <= exp_s1;
                        exp_s2_q   <= exp_s2;
                        idx        <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_mask  <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    err_count <= err_next;
                    fail_mask <= mask_next;
                    if (idx == 2'd3) begin
                        // pass must include this final vector, so it uses err_next.
                        pass  <= (err_next == 4'd0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        x_out <= 1'b0;
                        y_out <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx            <= idx + 2'd1;
                        {x_out, y_out} <= idx + 2'd1;
                        state          <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: a behavioural function stage (s = ~x | y)
// with fault modes, run against SETTLE=1 and SETTLE=3 instances.
module tb_tt_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start3;
    logic [3:0] exp_s1, exp_s2;
    logic       s1_in, s2_in, s3_f;

    logic       x1, y1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [7:0] mask1;
    logic       x3, y3, busy3, done3, pass3;
    logic [3:0] err3;
    logic [7:0] mask3;

    int   mode;
    logic four_state;
    logic probe;
    logic sel3;

    int checks;
    int failures;

    logic       m_done, m_busy, m_pass;
    logic [1:0] m_xy;
    logic [3:0] m_err;
    logic [7:0] m_mask;

    // mode 0: correct stage, 1: s2 stuck at 0, 2: s1 unknown (inverted on 2-state simulators)
    always_comb begin
        s1_in = ~x1 | y1;
        s2_in = ~x1 | y1;
        if (mode == 1) s2_in = 1'b0;
        if (mode == 2) s1_in = four_state ? 1'bx : ~(~x1 | y1);
    end

    assign s3_f = ~x3 | y3;

    always_comb begin
        if (sel3) begin
            m_done = done3; m_busy = busy3; m_pass = pass3;
            m_xy = {x3, y3}; m_err = err3; m_mask = mask3;
        end else begin
            m_done = done1; m_busy = busy1; m_pass = pass1;
            m_xy = {x1, y1}; m_err = err1; m_mask = mask1;
        end
    end

    tt_sweep_checker #(.SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .exp_s1(exp_s1), .exp_s2(exp_s2), .s1_in(s1_in), .s2_in(s2_in),
        .x_out(x1), .y_out(y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1)
    );

    tt_sweep_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .exp_s1(4'b1011), .exp_s2(4'b1011), .s1_in(s3_f), .s2_in(s3_f),
        .x_out(x3), .y_out(y3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_mask(mask3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Starts a sweep, then rewrites the expected tables to prove they were latched.
    task automatic run_sweep(input logic [3:0] post_s1, input logic [3:0] post_s2,
                             input int budget, output int lat, output int busy_cyc,
                             output logic [7:0] seq);
        logic [1:0] last;
        bit         have;
        pulse_start();
        exp_s1   = post_s1;
        exp_s2   = post_s2;
        lat      = 0;
        busy_cyc = 0;
        seq      = '0;
        have     = 0;
        last     = '0;
        forever begin
            @(negedge clk);
            if (m_busy) begin
                busy_cyc++;
                if (!have || m_xy != last) begin
                    seq  = {seq[5:0], m_xy};
                    last = m_xy;
                    have = 1;
                end
            end
            if (m_done || lat >= budget) break;
            @(posedge clk);
            lat++;
        end
        if (!m_done) check("done_timeout", {31'd0, m_done}, 32'd1);
    endtask

    task automatic wait_xy(input logic [1:0] v, input string tag);
        bit found;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m_busy && m_xy == v) begin
                found = 1;
                break;
            end
        end
        if (!found) check(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (m_done) n++;
        end
    endtask

    int         lat, bcyc, ndone;
    logic [7:0] seq;

    initial begin
        checks   = 0;
        failures = 0;
        probe    = 1'bx;
        four_state = (probe === 1'bx);
        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        sel3   = 1'b0;
        mode   = 0;
        exp_s1 = 4'b1011;
        exp_s2 = 4'b1011;
        repeat (3) @(negedge clk);
        check("rst_outputs", {22'd0, busy1, done1, pass1, err1, mask1, x1, y1}, 32'd0);
        check("rst_outputs3", {22'd0, busy3, done3, pass3, err3, mask3, x3, y3}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct stage, tables changed right after start.
        exp_s1 = 4'b1011; exp_s2 = 4'b1011;
        run_sweep(4'b0000, 4'b0100, 40, lat, bcyc, seq);
        check("t1_latency", lat, 8);
        check("t1_busy_cycles", bcyc, 8);
        check("t1_sequence", {24'd0, seq}, 32'h1B);
        check("t1_pass", {31'd0, m_pass}, 32'd1);
        check("t1_err", {28'd0, m_err}, 32'd0);
        check("t1_mask", {24'd0, m_mask}, 32'h00);
        @(negedge clk);
        check("t1_done_pulse", {31'd0, m_done}, 32'd0);
        check("t1_idle_busy", {31'd0, m_busy}, 32'd0);

        // Wrong expectation for s1 at index 2.
        exp_s1 = 4'b1111; exp_s2 = 4'b1011;
        run_sweep(4'b1111, 4'b1011, 40, lat, bcyc, seq);
        check("t2_err", {28'd0, m_err}, 32'd1);
        check("t2_mask", {24'd0, m_mask}, 32'h10);
        check("t2_pass", {31'd0, m_pass}, 32'd0);
        repeat (3) @(negedge clk);
        check("t2_hold_err", {28'd0, m_err}, 32'd1);
        check("t2_hold_mask", {24'd0, m_mask}, 32'h10);

        // s2 stuck at 0.
        mode = 1; exp_s1 = 4'b1011; exp_s2 = 4'b1011;
        run_sweep(4'b1011, 4'b1011, 40, lat, bcyc, seq);
        check("t3_err", {28'd0, m_err}, 32'd3);
        check("t3_mask", {24'd0, m_mask}, 32'h8A);
        check("t3_pass", {31'd0, m_pass}, 32'd0);
        mode = 0;

        // Re-pulsed start while busy must not restart the sweep.
        pulse_start();
        wait_xy(2'd1, "t4_reach_idx1");
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        count_dones(16, ndone);
        check("t4_single_done", ndone, 1);
        check("t4_pass", {31'd0, m_pass}, 32'd1);

        // Reset mid-sweep aborts with no done and clears everything.
        pulse_start();
        wait_xy(2'd2, "t4_reach_idx2");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t4_rst_outputs", {22'd0, busy1, done1, pass1, err1, mask1, x1, y1}, 32'd0);
        count_dones(12, ndone);
        check("t4_no_done", ndone, 0);
        check("t4_still_idle", {31'd0, m_busy}, 32'd0);
        run_sweep(4'b1011, 4'b1011, 40, lat, bcyc, seq);
        check("t4_rerun_latency", lat, 8);
        check("t4_rerun_pass", {31'd0, m_pass}, 32'd1);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        rst_n = 1'b0; start1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; start1 = 1'b0;
        check("t5_rst_priority_busy", {31'd0, busy1}, 32'd0);
        check("t5_rst_priority_pass", {31'd0, pass1}, 32'd0);
        count_dones(10, ndone);
        check("t5_rst_priority_nodone", ndone, 0);

        // Unknown s1 on every sample counts as a mismatch each time.
        mode = 2; exp_s1 = 4'b1011; exp_s2 = 4'b1011;
        run_sweep(4'b1011, 4'b1011, 40, lat, bcyc, seq);
        check("t6_err", {28'd0, m_err}, 32'd4);
        check("t6_mask", {24'd0, m_mask}, 32'h55);
        check("t6_pass", {31'd0, m_pass}, 32'd0);
        mode = 0;

        // Longer settle time.
        sel3 = 1'b1;
        run_sweep(4'b1011, 4'b1011, 60, lat, bcyc, seq);
        check("t7_latency", lat, 16);
        check("t7_busy_cycles", bcyc, 16);
        check("t7_sequence", {24'd0, seq}, 32'h1B);
        check("t7_pass", {31'd0, m_pass}, 32'd1);
        check("t7_err", {28'd0, m_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
